// File: rtl/shift_ex_stage.sv
// Shift execute stage (SLL/SRA/ROR): 1-cycle latency, 2-entry main+skid FIFO.
// In_Ready drops only when both entries are held; Flush empties the FIFO.
module shift_ex_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [1:0]       Opcode,
  input  logic [WIDTH-1:0] Operand,
  input  logic [3:0]       Shift_Val,
  input  logic [3:0]       Dst_Reg,
  input  logic             Flush,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Out_Dst,
  output logic             Z_Flag,
  output logic             Illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   skid_res;
  logic [3:0]         skid_dst;
  logic [WIDTH-1:0]   shift_res;
  logic [2*WIDTH-1:0] rot;
  logic               in_hs, out_hs, illegal_op, push;
  logic               load_main_in, load_main_skid, load_skid;

  always_comb begin
    rot = {Operand, Operand} >> Shift_Val;
    case (Opcode)
      2'b00:   shift_res = Operand << Shift_Val;
      2'b01:   shift_res = $unsigned($signed(Operand) >>> Shift_Val);
      2'b10:   shift_res = rot[WIDTH-1:0];
      default: shift_res = '0;
    endcase
  end

  assign in_hs      = In_Valid & In_Ready;
  assign out_hs     = Out_Valid & Out_Ready;
  assign illegal_op = (Opcode == 2'b11);
  // Illegal ops are consumed at the input but never occupy a FIFO slot.
  assign push       = in_hs & ~illegal_op;
  assign Out_Valid  = (state != EMPTY);

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (Flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (push && out_hs) begin
            load_main_in = 1'b1;
          end else if (push) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (out_hs) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_hs) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      In_Ready <= 1'b1;
      Illegal  <= 1'b0;
      Z_Flag   <= 1'b0;
      Result   <= '0;
      Out_Dst  <= '0;
      skid_res <= '0;
      skid_dst <= '0;
    end else begin
      In_Ready <= (state_nxt != FULL);
      Illegal  <= in_hs & illegal_op & ~Flush;
      if (out_hs && !Flush) Z_Flag <= (Result == '0);
      if (load_main_in) begin
        Result  <= shift_res;
        Out_Dst <= Dst_Reg;
      end else if (load_main_skid) begin
        Result  <= skid_res;
        Out_Dst <= skid_dst;
      end
      if (load_skid) begin
        skid_res <= shift_res;
        skid_dst <= Dst_Reg;
      end
    end
  end

endmodule
